rr_arbiter_fsm: RTL
===================

RR_ARBITER_FSM -- requirements
Module: rr_arbiter_fsm

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing the resource; legal range 2..16.
REQ-002 Parameter HOLD_MAX, default 8, maximum grant length in cycles; legal range 2..255.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 Port req  input  N_REQ  per-requester request, level.
REQ-006 Port done  input  N_REQ  per-requester release, sampled only for the current grantee.
REQ-007 Port lock  input  N_REQ  per-requester timeout-suppress; present in every build (see Configuration).
REQ-008 Port gnt  output  N_REQ  one-hot grant, registered.
REQ-009 Port gnt_id  output  clog2(N_REQ)  index of the current or last grantee, registered.
REQ-010 Port busy  output  1  high while in GRANT.
REQ-011 Port timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, GRANT and RELEASE.
REQ-013 Arbitration SHALL be round-robin: pick the first asserted req at index ptr, ptr+1, ... wrapping modulo N_REQ.
REQ-014 IDLE: if any req is high at edge t, the FSM SHALL enter GRANT with gnt/gnt_id valid from t+1; otherwise it SHALL stay in IDLE.
REQ-015 GRANT: gnt SHALL stay constant and one-hot; the hold counter SHALL be 0 in the first GRANT cycle and increment each cycle.
REQ-016 GRANT exits to RELEASE when, for grantee i, done[i]=1, or req[i]=0, or the counter equals HOLD_MAX-1.
REQ-017 A grant SHALL therefore last at most HOLD_MAX cycles.
REQ-018 timeout SHALL pulse during the RELEASE cycle only if exit was caused solely by the hold limit.
REQ-019 If done[i] or req[i]=0 coincides with the hold limit, there SHALL be no timeout pulse.
REQ-020 RELEASE SHALL hold gnt=0 and busy=0 for exactly one cycle, and SHALL set ptr to (gnt_id+1) mod N_REQ.
REQ-021 RELEASE SHALL arbitrate with the updated ptr: if any req is high, go to GRANT next cycle, else go to IDLE.
REQ-022 Minimum gap between consecutive grants SHALL be one cycle (done at t, gnt=0 at t+1, new gnt at t+2).
REQ-023 gnt_id SHALL hold the last grantee's index while gnt=0.
REQ-024 gnt SHALL never have more than one bit set, in any cycle.
REQ-025 Inputs of non-granted requesters, and done while not in GRANT, SHALL be ignored.

Reset
REQ-026 When rst=0 at a rising edge, the next cycle SHALL have state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, ptr=0 and hold counter=0.
REQ-027 Reset mid-grant SHALL drop gnt on the following cycle, with no timeout pulse.
REQ-028 After rst returns to 1, arbitration SHALL resume from ptr=0.

Configuration
REQ-029 Macro RR_ARBITER_LOCK_EN SHALL control hold-limit suppression.
REQ-030 With RR_ARBITER_LOCK_EN defined, lock[i]=1 for grantee i SHALL suppress the hold-limit exit; the counter SHALL saturate at HOLD_MAX-1.
REQ-031 With the macro defined, the hold-limit exit and timeout SHALL occur on the first cycle lock[i]=0 with the counter saturated.
REQ-032 Without RR_ARBITER_LOCK_EN, the lock port SHALL be ignored and the behaviour SHALL be exactly REQ-016..018.

Verification
REQ-033 N_REQ=4: req=4'b0101 from IDLE with ptr=0 -> gnt=0001 next cycle; done[0] -> gap cycle -> gnt=0100.
REQ-034 HOLD_MAX=8: req[2] held, done never -> gnt=0100 for exactly 8 cycles, then timeout=1 for 1 cycle with gnt=0.
REQ-035 done[1] and the hold limit in the same cycle -> RELEASE with timeout=0.
REQ-036 rst=0 during cycle 3 of a grant -> gnt=0, busy=0, gnt_id=0 next cycle; then req=1000 -> gnt=1000.
REQ-037 All 4 req held, each grantee asserts done after 2 cycles -> grant order 0,1,2,3,0, with a 1-cycle gap each.
REQ-038 RR_ARBITER_LOCK_EN defined, lock[3]=1 for 20 cycles -> gnt=1000 for 20 cycles; lock drops -> timeout pulse next cycle.

Source files
------------

// File: rtl/rr_arbiter_fsm.sv
// Round-robin arbiter with a bounded hold time per grant (IDLE / GRANT / RELEASE).
// Define RR_ARBITER_LOCK_EN to let lock[i] of the grantee suppress the hold-limit revoke.
module rr_arbiter_fsm #(
    parameter int N_REQ    = 4,
    parameter int HOLD_MAX = 8,
    localparam int IDW     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] done,
    input  logic [N_REQ-1:0] lock,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_id,
    output logic             busy,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic [7:0]     HOLD_LAST = 8'(HOLD_MAX - 1);
    localparam logic [IDW-1:0] ID_LAST   = IDW'(N_REQ - 1);
    localparam logic [IDW-1:0] ID_ONE    = IDW'(1);

    state_t             state_r, state_s;
    logic [IDW-1:0]     ptr_r, ptr_s;
    logic [7:0]         hold_r, hold_s;
    logic [N_REQ-1:0]   gnt_r, gnt_s;
    logic [IDW-1:0]     gnt_id_r, gnt_id_s;
    logic               busy_r, busy_s;
    logic               timeout_r, timeout_s;

    logic               any_req_s;
    logic [IDW-1:0]     win_id_s;
    logic               cur_done_s, cur_req_s, at_limit_s, limit_exit_s, release_s;

    // Round-robin search starting at ptr; the descending loop lets the lowest offset win.
    always_comb begin
        any_req_s = 1'b0;
        win_id_s  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            any_req_s = any_req_s | req[(int'(ptr_r) + k) % N_REQ];
            win_id_s  = req[(int'(ptr_r) + k) % N_REQ] ? IDW'((int'(ptr_r) + k) % N_REQ) : win_id_s;
        end
    end

`ifdef RR_ARBITER_LOCK_EN
    // Grant-exit conditions for the current grantee, with lock holding off the hold limit.
    always_comb begin
        cur_done_s   = done[gnt_id_r];
        cur_req_s    = req[gnt_id_r];
        at_limit_s   = (hold_r == HOLD_LAST);
        limit_exit_s = at_limit_s & ~lock[gnt_id_r];
        release_s    = cur_done_s | ~cur_req_s | limit_exit_s;
    end
`else
    logic unused_lock_s;
    assign unused_lock_s = ^lock;

    // Grant-exit conditions for the current grantee.
    always_comb begin
        cur_done_s   = done[gnt_id_r];
        cur_req_s    = req[gnt_id_r];
        at_limit_s   = (hold_r == HOLD_LAST);
        limit_exit_s = at_limit_s;
        release_s    = cur_done_s | ~cur_req_s | limit_exit_s;
    end
`endif

    // State register together with the registered outputs and arbitration state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r   <= IDLE;
            ptr_r     <= '0;
            hold_r    <= 8'd0;
            gnt_r     <= '0;
            gnt_id_r  <= '0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            ptr_r     <= ptr_s;
            hold_r    <= hold_s;
            gnt_r     <= gnt_s;
            gnt_id_r  <= gnt_id_s;
            busy_r    <= busy_s;
            timeout_r <= timeout_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    state_s = any_req_s ? GRANT : IDLE;
            GRANT:   state_s = release_s ? RELEASE : GRANT;
            RELEASE: state_s = any_req_s ? GRANT : IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and hold counter.
    always_comb begin
        ptr_s     = ptr_r;
        hold_s    = hold_r;
        gnt_s     = gnt_r;
        gnt_id_s  = gnt_id_r;
        busy_s    = busy_r;
        timeout_s = 1'b0;
        case (state_r)
            IDLE, RELEASE: begin
                hold_s = 8'd0;
                if (any_req_s) begin
                    gnt_s    = {{(N_REQ-1){1'b0}}, 1'b1} << win_id_s;
                    gnt_id_s = win_id_s;
                    busy_s   = 1'b1;
                end else begin
                    gnt_s    = '0;
                    busy_s   = 1'b0;
                end
            end
            GRANT: begin
                if (release_s) begin
                    gnt_s     = '0;
                    busy_s    = 1'b0;
                    hold_s    = 8'd0;
                    ptr_s     = (gnt_id_r == ID_LAST) ? '0 : gnt_id_r + ID_ONE;
                    // Timeout only when the hold limit is the sole reason for leaving.
                    timeout_s = limit_exit_s & cur_req_s & ~cur_done_s;
                end else begin
                    hold_s    = at_limit_s ? hold_r : hold_r + 8'd1;
                end
            end
            default: begin
                gnt_s  = '0;
                busy_s = 1'b0;
                hold_s = 8'd0;
            end
        endcase
    end

    assign gnt     = gnt_r;
    assign gnt_id  = gnt_id_r;
    assign busy    = busy_r;
    assign timeout = timeout_r;

endmodule
